// File: rtl/alu_rb_sequencer.sv
// ---------------------------------------------------------------------------
// alu_rb_sequencer
//
// Purpose:
//   Accepts one 32-bit instruction at a time and turns it into the per-cycle
//   control strobes for an ALU + register-bank stage (R0-R7).
//   ALU reg-reg instructions take two cycles (EXEC then WB). LOADI and NOP
//   take one cycle. Rejected instructions take one ERR cycle.
//
//   Handshake: an instruction transfers on a rising edge where in_valid and
//   in_ready are both 1. in_ready is 1 only in IDLE. While the block is busy,
//   in_valid and in_instr are ignored. in_instr and in_imm are captured on the
//   transfer edge.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   instruction handshake
//   in_instr            [31:30] kind, [29:26] alu op, [25:22] rd,
//                       [21:18] rs1, [17:14] rs2, [13:0] unused
//   in_imm              LOADI immediate
//   op                  ALU opcode
//   rp1, rp2            read-port enables
//   ap1, ap2            read addresses
//   wp                  write-port enable
//   w                   write source (1 = ext_write, 0 = ALU result)
//   apw                 write address
//   ext_write           external write data
//   done                retire pulse
//   illegal             reject pulse
//   busy                high whenever the state is not IDLE
//   retired             wrapping count of retired instructions
//   dbg_state           current FSM state, for observation only
// ---------------------------------------------------------------------------
module alu_rb_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_imm,
  output logic [3:0]  op,
  output logic        rp1,
  output logic        rp2,
  output logic [3:0]  ap1,
  output logic [3:0]  ap2,
  output logic        wp,
  output logic        w,
  output logic [3:0]  apw,
  output logic [31:0] ext_write,
  output logic        done,
  output logic        illegal,
  output logic        busy,
  output logic [15:0] retired,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_WB   = 3'd2,
    S_LOAD = 3'd3,
    S_NOP  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [1:0] K_ALU   = 2'b00;
  localparam logic [1:0] K_LOADI = 2'b01;
  localparam logic [1:0] K_NOP   = 2'b10;

  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_MAX  = 4'd8;

  state_t      r_state;
  logic        r_in_ready;
  logic [3:0]  r_op;
  logic        r_rp1;
  logic        r_rp2;
  logic [3:0]  r_ap1;
  logic [3:0]  r_ap2;
  logic        r_wp;
  logic        r_w;
  logic [3:0]  r_apw;
  logic [31:0] r_ext_write;
  logic        r_done;
  logic        r_illegal;
  logic        r_busy;
  logic [15:0] r_retired;
  logic [3:0]  r_rd;

  // Field decode of the offered instruction.
  logic [1:0]  w_kind;
  logic [3:0]  w_alu_op;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs1;
  logic [3:0]  w_rs2;
  logic        w_is_not;
  logic        w_alu_legal;
  logic        w_load_legal;
  logic        w_unused_bits;

  assign w_kind   = in_instr[31:30];
  assign w_alu_op = in_instr[29:26];
  assign w_rd     = in_instr[25:22];
  assign w_rs1    = in_instr[21:18];
  assign w_rs2    = in_instr[17:14];
  assign w_unused_bits = ^in_instr[13:0];

  assign w_is_not = (w_alu_op == OP_NOT);

  // Register addresses 8-15 have bit 3 set. NOT has no second operand, so rs2
  // is not checked for it; LOADI only writes rd, so only rd is checked.
  assign w_alu_legal  = (w_kind == K_ALU) && (w_alu_op <= OP_MAX) &&
                        !w_rd[3] && !w_rs1[3] && (w_is_not || !w_rs2[3]);
  assign w_load_legal = (w_kind == K_LOADI) && !w_rd[3];

  // All outputs are registered and describe the current state. Because every
  // register is asynchronously reset, the strobes, done and busy fall the
  // moment rst_n goes low, which aborts an in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_op        <= '0;
      r_rp1       <= 1'b0;
      r_rp2       <= 1'b0;
      r_ap1       <= '0;
      r_ap2       <= '0;
      r_wp        <= 1'b0;
      r_w         <= 1'b0;
      r_apw       <= '0;
      r_ext_write <= '0;
      r_done      <= 1'b0;
      r_illegal   <= 1'b0;
      r_busy      <= 1'b0;
      r_retired   <= '0;
      r_rd        <= '0;
    end else begin
      // Quiet defaults: the state arms below set only what they drive.
      r_in_ready  <= 1'b0;
      r_op        <= '0;
      r_rp1       <= 1'b0;
      r_rp2       <= 1'b0;
      r_ap1       <= '0;
      r_ap2       <= '0;
      r_wp        <= 1'b0;
      r_w         <= 1'b0;
      r_apw       <= '0;
      r_ext_write <= '0;
      r_done      <= 1'b0;
      r_illegal   <= 1'b0;
      r_busy      <= 1'b0;

      // The count follows the done pulse that is visible this cycle.
      if (r_done) begin
        r_retired <= r_retired + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rd   <= w_rd;
            r_busy <= 1'b1;
            if (w_alu_legal) begin
              r_state <= S_EXEC;
              r_op    <= w_alu_op;
              r_ap1   <= w_rs1;
              r_ap2   <= w_rs2;
              r_rp1   <= 1'b1;
              r_rp2   <= !w_is_not;
            end else if (w_load_legal) begin
              r_state     <= S_LOAD;
              r_wp        <= 1'b1;
              r_w         <= 1'b1;
              r_apw       <= w_rd;
              r_ext_write <= in_imm;
              r_done      <= 1'b1;
            end else if (w_kind == K_NOP) begin
              r_state <= S_NOP;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_ERR;
              r_illegal <= 1'b1;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end

        S_EXEC: begin
          // Read side is held through WB so the ALU result stays stable while
          // it is written back.
          r_state <= S_WB;
          r_busy  <= 1'b1;
          r_op    <= r_op;
          r_ap1   <= r_ap1;
          r_ap2   <= r_ap2;
          r_rp1   <= r_rp1;
          r_rp2   <= r_rp2;
          r_wp    <= 1'b1;
          r_w     <= 1'b0;
          r_apw   <= r_rd;
          r_done  <= 1'b1;
        end

        default: begin
          // WB, LOAD, NOP and ERR all last one cycle and return to IDLE.
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign op        = r_op;
  assign rp1       = r_rp1;
  assign rp2       = r_rp2;
  assign ap1       = r_ap1;
  assign ap2       = r_ap2;
  assign wp        = r_wp;
  assign w         = r_w;
  assign apw       = r_apw;
  assign ext_write = r_ext_write;
  assign done      = r_done;
  assign illegal   = r_illegal;
  assign busy      = r_busy;
  assign retired   = r_retired;
  assign dbg_state = r_state;

endmodule
